dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the MEM stage of the RISC-V pipeline.
- Accepts load/store requests and returns sign- or zero-extended load data.
- Asserts `busy` so hazard control can drop the `write` enable on the pipeline registers until the access completes.
- Implements byte-addressed word memory with fixed, parameterised access latency and misalignment detection.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥4.
- LATENCY, 2, cycles from request acceptance to response; ≥1.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- req_read  input  1  load request (MemRead_MEM)
- req_write  input  1  store request (MemWrite_MEM)
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (rs2 value)
- funct3  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- read_data  output  32  extended load data, valid when `done`
- busy  output  1  stall request to pipeline/hazard unit
- done  output  1  one-cycle response pulse
- err  output  1  misaligned or illegal-funct3 flag, valid with `done`

Behaviour:
- Reset (reset is synchronous, active-high, on clk):
  - FSM goes to IDLE; counter 0.
  - `read_data`=0, `done`=0, `err`=0.
  - `busy`=0 except combinationally when a request is present in IDLE.
  - Memory array contents not reset.
- FSM IDLE:
  - If `req_write` or `req_read` is high, latch address, write_data, funct3 and type (write wins if both high; then treated as store only).
  - Load counter=LATENCY-1.
  - Go to WAIT if LATENCY>1, else RESP.
- FSM WAIT: decrement counter each cycle; at counter==1 go to RESP.
- FSM RESP (one cycle):
  - `done`=1; `read_data`/`err` valid.
  - Next state IDLE unconditionally.
- busy: combinational `(IDLE & (req_read|req_write)) | WAIT`; low in RESP. A request is therefore stalled for exactly LATENCY cycles and advances on the RESP edge.
- Re-request: after RESP, IDLE sees whatever request the MEM stage now presents. A request still held because another stall source froze the pipeline is re-executed (loads harmless; stores rewrite identical data).
- Word index: `address[log2(DEPTH_WORDS)+1:2]`; upper address bits ignored (wrap modulo memory size).
- Alignment rules:
  - Halfword requires `address[0]`=0.
  - Word requires `address[1:0]`=0.
  - funct3 011/110/111 is illegal.
  - Any violation: no memory write; `read_data`=0; `err`=1 in RESP.
- Stores:
  - Commit on the clock edge entering RESP.
  - sb writes byte lane `address[1:0]` with `write_data[7:0]`.
  - sh writes lanes {1,0} or {3,2} with `write_data[15:0]`.
  - sw writes all lanes. Other lanes are untouched.
- Loads:
  - Word read on the edge entering RESP, registered into `read_data`.
  - lb/lh sign-extend; lbu/lhu zero-extend the selected lane(s).
  - For stores, `read_data`=0.
- Store followed by load to the same word returns the newly stored data (sequential accesses, no overlap).
- Reset mid-WAIT: access aborted; a pending store is not committed; `done` not pulsed.
- `read_data` and `err` hold their value after RESP until the next RESP or reset. `done` is low outside RESP.

Test Plan:
- Reset, LATENCY=2: sw 0xDEADBEEF to 0x10 → `busy`=1 for 2 cycles, `done` pulse in cycle 2, `err`=0. Then lw 0x10 → `read_data`=0xDEADBEEF.
- Byte/half lanes: sb 0x80 to 0x21; lb 0x21 → 0xFFFFFF80; lbu 0x21 → 0x00000080. sh 0x8001 to 0x22; lhu 0x22 → 0x00008001; lw 0x20 → 0x80018000 when lane 0 is 0x00.
- Misalignment: lw 0x13 → `done` with `err`=1, `read_data`=0. sh to 0x15 → `err`=1, and the word at 0x14 is unchanged on a later lw.
- LATENCY=1: back-to-back lw requests → `busy` high 1 cycle each, `done` every second cycle, correct data each time.
- Reset asserted during WAIT of sw 0x12345678 to 0x40 → no `done`. Later lw 0x40 returns prior contents, not 0x12345678.
- `req_read` and `req_write` both high, sw 0xA5A5A5A5 to 0x8 → treated as store, `read_data`=0. Address 0x408 with DEPTH_WORDS=256 → aliases word 0x8.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte-addressed word memory with a fixed
// access latency, sub-word load extension and misalignment / illegal-size detection.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    funct3_q;
    logic          store_q;
    logic [31:0]   read_data_q;
    logic          err_q;
    logic          done_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          capture_s;
    logic          enter_resp_s;
    logic [AW+1:0] op_addr_s;
    logic [31:0]   op_wdata_s;
    logic [2:0]    op_funct3_s;
    logic          op_store_s;
    logic          op_err_s;
    logic [AW-1:0] op_idx_s;
    logic [3:0]    op_be_s;
    logic [31:0]   op_wrep_s;
    logic          mem_we_s;
    logic          unused_addr_s;

    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return (a != 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            3'b010:  return word;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << a;
            3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
            3'b010:         return 4'b1111;
            default:        return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000, 3'b100: return {4{wd[7:0]}};
            3'b001, 3'b101: return {2{wd[15:0]}};
            default:        return wd;
        endcase
    endfunction

    // Next-state logic; LATENCY==1 skips WAIT and enters RESP on the acceptance edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_s    = 1'b0;
        enter_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_read || req_write) begin
                    capture_s = 1'b1;
                    cnt_d     = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // In IDLE the live request is the operand; afterwards the latched copy is.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_addr_s   = address[AW+1:0];
            op_wdata_s  = write_data;
            op_funct3_s = funct3;
            op_store_s  = req_write;
        end else begin
            op_addr_s   = addr_q;
            op_wdata_s  = wdata_q;
            op_funct3_s = funct3_q;
            op_store_s  = store_q;
        end
    end

    assign op_idx_s      = op_addr_s[AW+1:2];
    assign op_err_s      = access_err(op_funct3_s, op_addr_s[1:0]);
    assign op_be_s       = store_be(op_funct3_s, op_addr_s[1:0]);
    assign op_wrep_s     = store_rep(op_funct3_s, op_wdata_s);
    assign mem_we_s      = enter_resp_s & ~reset & op_store_s & ~op_err_s;
    assign unused_addr_s = ^address[31:AW+2];

    // Memory array: byte-lane writes on the edge entering RESP, never reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be_s[i]) begin
                    mem_q[op_idx_s][8*i +: 8] <= op_wrep_s[8*i +: 8];
                end
            end
        end
    end

    // Control state, request capture and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= 32'h00000000;
            funct3_q    <= 3'b000;
            store_q     <= 1'b0;
            read_data_q <= 32'h00000000;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= enter_resp_s;
            if (capture_s) begin
                addr_q   <= address[AW+1:0];
                wdata_q  <= write_data;
                funct3_q <= funct3;
                store_q  <= req_write;
            end
            if (enter_resp_s) begin
                err_q       <= op_err_s;
                read_data_q <= (op_store_s || op_err_s) ? 32'h00000000
                             : load_extend(mem_q[op_idx_s], op_funct3_s, op_addr_s[1:0]);
            end
        end
    end

    assign busy      = ((state_q == S_IDLE) && (req_read || req_write)) || (state_q == S_WAIT);
    assign done      = done_q;
    assign err       = err_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=1 responder checked against a
// byte-granular memory model with directed and randomized accesses.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rd2, wr2, busy2, done2, err2;
    logic [31:0] a2, wd2, rdata2;
    logic [2:0]  f2;
    logic        rst1, rd1, wr1, busy1, done1, err1;
    logic [31:0] a1, wd1, rdata1;
    logic [2:0]  f1;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(rst2), .req_read(rd2), .req_write(wr2), .address(a2),
        .write_data(wd2), .funct3(f2), .read_data(rdata2), .busy(busy2), .done(done2), .err(err2));

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst1), .req_read(rd1), .req_write(wr1), .address(a1),
        .write_data(wd1), .funct3(f1), .read_data(rdata1), .busy(busy1), .done(done1), .err(err1));

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [int];   // key = sel*4096 + byte address modulo 1024

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy1 : busy2;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel != 0) ? done1 : done2;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel != 0) ? err1 : err2;
    endfunction
    function automatic logic [31:0] get_rd(input int sel);
        return (sel != 0) ? rdata1 : rdata2;
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
        if (sel != 0) begin
            rd1 = rd; wr1 = wr; a1 = addr; wd1 = wd; f1 = f3;
        end else begin
            rd2 = rd; wr2 = wr; a2 = addr; wd2 = wd; f2 = f3;
        end
    endtask

    // Reference: bytes addressed directly; sizes/signs from funct3; store wins over load.
    task automatic model_access(input int sel, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] exp_rd, output logic exp_err,
                                output logic known);
        int size;
        logic sgn;
        logic [31:0] v;
        int key;
        size = 0; sgn = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd4: size = 1;
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd5: size = 2;
            3'd2: size = 4;
            default: size = 0;
        endcase
        exp_err = (size == 0) || ((int'(addr[1:0]) % size) != 0);
        exp_rd  = 32'h0;
        known   = 1'b1;
        if (!exp_err && wr) begin
            for (int k = 0; k < size; k++) begin
                key = sel * 4096 + ((int'(addr[9:0]) + k) % 1024);
                mb[key] = 8'(wd >> (8 * k));
            end
        end else if (!exp_err) begin
            v = 32'h0;
            for (int k = 0; k < size; k++) begin
                key = sel * 4096 + ((int'(addr[9:0]) + k) % 1024);
                if (mb.exists(key)) v = v | (32'(mb[key]) << (8 * k));
                else known = 1'b0;
            end
            if (sgn && v[8*size-1]) v = v - (32'd1 << (8 * size));
            exp_rd = v;
        end
    endtask

    // One request from an idle negedge through RESP and one cycle beyond.
    task automatic access(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] obs_rd, output logic obs_err);
        logic [31:0] exp_rd;
        logic exp_err, known;
        int lat, edges, busy_n;
        lat = (sel != 0) ? 1 : 2;
        model_access(sel, wr, addr, wd, f3, exp_rd, exp_err, known);
        drive(sel, rd, wr, addr, wd, f3);
        edges = 0; busy_n = 0;
        #1;
        while (!get_done(sel) && edges < 20) begin
            if (get_busy(sel)) busy_n++;
            @(posedge clk); @(negedge clk);
            edges++;
        end
        obs_rd = get_rd(sel); obs_err = get_err(sel);
        checks++;
        if (edges !== lat) begin
            errors++; $display("FAIL latency dut%0d addr=%h: got %0d edges, expected %0d", sel, addr, edges, lat);
        end
        checks++;
        if (busy_n !== lat) begin
            errors++; $display("FAIL busy_cycles dut%0d addr=%h: got %0d, expected %0d", sel, addr, busy_n, lat);
        end
        checks++;
        if (obs_err !== exp_err) begin
            errors++; $display("FAIL err dut%0d addr=%h f3=%0d: got %b, expected %b", sel, addr, f3, obs_err, exp_err);
        end
        if (known) begin
            checks++;
            if (obs_rd !== exp_rd) begin
                errors++; $display("FAIL read_data dut%0d addr=%h f3=%0d: got %h, expected %h", sel, addr, f3, obs_rd, exp_rd);
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        #1;
        checks++;
        if (get_busy(sel) !== 1'b0) begin
            errors++; $display("FAIL busy_in_resp dut%0d: got %b, expected 0", sel, get_busy(sel));
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (get_done(sel) !== 1'b0) begin
            errors++; $display("FAIL done_after_resp dut%0d: got %b, expected 0", sel, get_done(sel));
        end
        if (known) begin
            checks++;
            if (get_rd(sel) !== exp_rd) begin
                errors++; $display("FAIL read_data_hold dut%0d: got %h, expected %h", sel, get_rd(sel), exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (get_rd(s) !== 32'h0) begin
                errors++; $display("FAIL reset_read_data dut%0d: got %h, expected 0", s, get_rd(s));
            end
            checks++;
            if ({get_done(s), get_err(s), get_busy(s)} !== 3'b000) begin
                errors++; $display("FAIL reset_flags dut%0d: got %b, expected 000", s, {get_done(s), get_err(s), get_busy(s)});
            end
        end
        rst1 = 1'b0; rst2 = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] r; logic e;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, r, e);
        checks++;
        if (r !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL sw_resp: got rd=%h err=%b, expected 0/0", r, e);
        end
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2, r, e);
        checks++;
        if (r !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_0x10: got %h, expected deadbeef", r);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] r; logic e;
        access(0, 1'b0, 1'b1, 32'h20, 32'h0, 3'd2, r, e);
        access(0, 1'b0, 1'b1, 32'h21, 32'h80, 3'd0, r, e);
        access(0, 1'b1, 1'b0, 32'h21, 32'h0, 3'd0, r, e);
        checks++;
        if (r !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb_0x21: got %h, expected ffffff80", r);
        end
        access(0, 1'b1, 1'b0, 32'h21, 32'h0, 3'd4, r, e);
        checks++;
        if (r !== 32'h00000080) begin
            errors++; $display("FAIL lbu_0x21: got %h, expected 00000080", r);
        end
        access(0, 1'b0, 1'b1, 32'h22, 32'h8001, 3'd1, r, e);
        access(0, 1'b1, 1'b0, 32'h22, 32'h0, 3'd5, r, e);
        checks++;
        if (r !== 32'h00008001) begin
            errors++; $display("FAIL lhu_0x22: got %h, expected 00008001", r);
        end
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'd2, r, e);
        checks++;
        if (r !== 32'h80018000) begin
            errors++; $display("FAIL lw_0x20: got %h, expected 80018000", r);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] r; logic e;
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, 3'd2, r, e);
        checks++;
        if (e !== 1'b1 || r !== 32'h0) begin
            errors++; $display("FAIL lw_misaligned: got err=%b rd=%h, expected 1/0", e, r);
        end
        access(0, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 3'd2, r, e);
        access(0, 1'b0, 1'b1, 32'h15, 32'hFFFF, 3'd1, r, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL sh_misaligned: got err=%b, expected 1", e);
        end
        access(0, 1'b1, 1'b0, 32'h14, 32'h0, 3'd2, r, e);
        checks++;
        if (r !== 32'h0BADF00D) begin
            errors++; $display("FAIL lw_0x14_unchanged: got %h, expected 0badf00d", r);
        end
        access(0, 1'b1, 1'b0, 32'h14, 32'h0, 3'd6, r, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL illegal_funct3: got err=%b, expected 1", e);
        end
    endtask

    task automatic test_both_and_alias();
        logic [31:0] r; logic e;
        access(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 3'd2, r, e);
        checks++;
        if (r !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL both_req_store: got rd=%h err=%b, expected 0/0", r, e);
        end
        access(0, 1'b1, 1'b0, 32'h408, 32'h0, 3'd2, r, e);
        checks++;
        if (r !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL alias_0x408: got %h, expected a5a5a5a5", r);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r; logic e;
        access(0, 1'b0, 1'b1, 32'h40, 32'h11111111, 3'd2, r, e);
        drive(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 3'd2);
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy2 !== 1'b1) begin
            errors++; $display("FAIL busy_in_wait: got %b, expected 1", busy2);
        end
        rst2 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        @(posedge clk); @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got done=%b busy=%b, expected 0/0", done2, busy2);
        end
        rst2 = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || rdata2 !== 32'h0) begin
            errors++; $display("FAIL abort_after: got done=%b rd=%h, expected 0/0", done2, rdata2);
        end
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 3'd2, r, e);
        checks++;
        if (r !== 32'h11111111) begin
            errors++; $display("FAIL lw_0x40_after_abort: got %h, expected 11111111", r);
        end
    endtask

    // LATENCY=1 with the read request held and the address advanced on each RESP.
    task automatic test_back_to_back();
        logic [31:0] r, exp_rd; logic e, exp_err, known;
        for (int i = 0; i < 4; i++) access(1, 1'b0, 1'b1, 32'(4 * i), $urandom(), 3'd2, r, e);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
        for (int i = 0; i < 4; i++) begin
            model_access(1, 1'b0, 32'(4 * i), 32'h0, 3'd2, exp_rd, exp_err, known);
            #1;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++; $display("FAIL b2b_idle%0d: got busy=%b done=%b, expected 1/0", i, busy1, done1);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || rdata1 !== exp_rd) begin
                errors++; $display("FAIL b2b_resp%0d: got done=%b busy=%b rd=%h, expected 1/0/%h", i, done1, busy1, rdata1, exp_rd);
            end
            if (i < 3) drive(1, 1'b1, 1'b0, 32'(4 * (i + 1)), 32'h0, 3'd2);
            else drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] r; logic e;
        int kind;
        logic [2:0] f3;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                kind = int'($urandom_range(1, 3));
                f3 = 3'($urandom_range(0, 7));
                access(s, kind[0], kind[1], $urandom() & 32'hFFFFFC7F, $urandom(), f3, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_misalign();
        test_both_and_alias();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
